// File: rtl/zeroheti_obi_interconnect.sv
// Parametrised OBI interconnect: NumMgr managers to NumSbr subordinates, RR arbitration, in-order responses.
// Optional per-manager stall counters are enabled by defining ZEROHETI_XBAR_STALL_CNT_EN.
module zeroheti_obi_interconnect #(
  parameter int unsigned                   NumMgr       = 3,
  parameter int unsigned                   NumSbr       = 6,
  parameter int unsigned                   MaxTrans     = 2,
  parameter logic [NumSbr-1:0][31:0]       AddrBase     = '0,
  parameter logic [NumSbr-1:0][31:0]       AddrLast     = '0,
  parameter logic [NumMgr-1:0][NumSbr-1:0] Connectivity = '1,
  parameter logic [31:0]                   ErrRdata     = 32'hBADCAB1E
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef ZEROHETI_XBAR_STALL_CNT_EN
  input  logic                         clear_stall_i,
  output logic [NumMgr-1:0][15:0]      stall_cnt_o,
`endif
  input  logic [NumMgr-1:0]            mgr_req_i,
  input  logic [NumMgr-1:0][31:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]            mgr_we_i,
  input  logic [NumMgr-1:0][3:0]       mgr_be_i,
  input  logic [NumMgr-1:0][31:0]      mgr_wdata_i,
  output logic [NumMgr-1:0]            mgr_gnt_o,
  output logic [NumMgr-1:0]            mgr_rvalid_o,
  output logic [NumMgr-1:0][31:0]      mgr_rdata_o,
  output logic [NumMgr-1:0]            mgr_err_o,
  output logic [NumSbr-1:0]            sbr_req_o,
  output logic [NumSbr-1:0][31:0]      sbr_addr_o,
  output logic [NumSbr-1:0]            sbr_we_o,
  output logic [NumSbr-1:0][3:0]       sbr_be_o,
  output logic [NumSbr-1:0][31:0]      sbr_wdata_o,
  input  logic [NumSbr-1:0]            sbr_gnt_i,
  input  logic [NumSbr-1:0]            sbr_rvalid_i,
  input  logic [NumSbr-1:0][31:0]      sbr_rdata_i,
  input  logic [NumSbr-1:0]            sbr_err_i
);
  localparam int unsigned MW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned TW = $clog2(NumSbr + 1);
  localparam int unsigned CW = $clog2(MaxTrans + 1);
  localparam int unsigned PW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam logic [TW-1:0] TgtErr = TW'(NumSbr);

  logic [NumMgr-1:0][TW-1:0]               tgt_s;
  logic [NumMgr-1:0]                       elig_s;
  logic [NumSbr:0]                         arb_found_s;
  logic [NumSbr:0][MW-1:0]                 arb_win_s;
  logic [NumMgr-1:0][CW-1:0]               out_cnt_q, out_cnt_d;
  logic [NumMgr-1:0][TW-1:0]               last_tgt_q, last_tgt_d;
  logic [NumSbr:0][MW-1:0]                 rr_q, rr_d;
  logic [NumSbr-1:0][MaxTrans-1:0][MW-1:0] fifo_q, fifo_d;
  logic [NumSbr-1:0][PW-1:0]               fwptr_q, fwptr_d, frptr_q, frptr_d;
  logic [NumSbr-1:0][CW-1:0]               fcnt_q, fcnt_d;
  logic                                    err_vld_q, err_vld_d;
  logic [MW-1:0]                           err_mgr_q, err_mgr_d;

  // Address decode (lowest matching reachable region wins) and ordering eligibility.
  always_comb begin
    for (int m = 0; m < NumMgr; m++) begin
      tgt_s[m] = TgtErr;
      for (int s = NumSbr - 1; s >= 0; s--) begin
        tgt_s[m] = (Connectivity[m][s] && (mgr_addr_i[m] >= AddrBase[s]) &&
                    (mgr_addr_i[m] <= AddrLast[s])) ? TW'(s) : tgt_s[m];
      end
      elig_s[m] = mgr_req_i[m] && ((out_cnt_q[m] == CW'(0)) ||
                  ((out_cnt_q[m] < CW'(MaxTrans)) && (tgt_s[m] == last_tgt_q[m])));
    end
  end

  // Round-robin pick per target; index NumSbr is the decode-error responder.
  always_comb begin
    int idx;
    idx = 0;
    for (int t = 0; t <= NumSbr; t++) begin
      arb_found_s[t] = 1'b0;
      arb_win_s[t]   = '0;
      for (int k = 0; k < NumMgr; k++) begin
        idx = (int'(rr_q[t]) + k) % int'(NumMgr);
        if (!arb_found_s[t] && elig_s[idx] && (tgt_s[idx] == TW'(t))) begin
          arb_found_s[t] = 1'b1;
          arb_win_s[t]   = MW'(idx);
        end else begin
          arb_found_s[t] = arb_found_s[t];
        end
      end
    end
  end

  // Request forwarding, grant return and response routing.
  always_comb begin
    sbr_req_o    = '0;
    sbr_addr_o   = '0;
    sbr_we_o     = '0;
    sbr_be_o     = '0;
    sbr_wdata_o  = '0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    mgr_rdata_o  = '0;
    mgr_err_o    = '0;
    for (int s = 0; s < NumSbr; s++) begin
      if (arb_found_s[s] && (fcnt_q[s] != CW'(MaxTrans))) begin
        sbr_req_o[s]                = 1'b1;
        sbr_addr_o[s]               = mgr_addr_i[arb_win_s[s]];
        sbr_we_o[s]                 = mgr_we_i[arb_win_s[s]];
        sbr_be_o[s]                 = mgr_be_i[arb_win_s[s]];
        sbr_wdata_o[s]              = mgr_wdata_i[arb_win_s[s]];
        mgr_gnt_o[arb_win_s[s]]     = sbr_gnt_i[s];
      end else begin
        sbr_req_o[s] = 1'b0;
      end
      if (sbr_rvalid_i[s] && (fcnt_q[s] != CW'(0))) begin
        mgr_rvalid_o[fifo_q[s][frptr_q[s]]] = 1'b1;
        mgr_rdata_o[fifo_q[s][frptr_q[s]]]  = sbr_rdata_i[s];
        mgr_err_o[fifo_q[s][frptr_q[s]]]    = sbr_err_i[s];
      end else begin
        mgr_rvalid_o = mgr_rvalid_o;
      end
    end
    if (arb_found_s[NumSbr]) begin
      mgr_gnt_o[arb_win_s[NumSbr]] = 1'b1;
    end else begin
      mgr_gnt_o = mgr_gnt_o;
    end
    if (err_vld_q) begin
      mgr_rvalid_o[err_mgr_q] = 1'b1;
      mgr_rdata_o[err_mgr_q]  = ErrRdata;
      mgr_err_o[err_mgr_q]    = 1'b1;
    end else begin
      mgr_err_o = mgr_err_o;
    end
  end

  // Next state: RR pointers, per-subordinate ID FIFOs, outstanding counters, error responder.
  always_comb begin
    logic hs, push, pop;
    err_vld_d  = arb_found_s[NumSbr];
    err_mgr_d  = arb_win_s[NumSbr];
    fifo_d     = fifo_q;
    for (int t = 0; t <= NumSbr; t++) begin
      hs = (t < NumSbr) ? (sbr_req_o[t] && sbr_gnt_i[t]) : arb_found_s[NumSbr];
      rr_d[t] = !hs ? rr_q[t] :
                (arb_win_s[t] == MW'(NumMgr - 1)) ? MW'(0) : arb_win_s[t] + MW'(1);
    end
    for (int s = 0; s < NumSbr; s++) begin
      push = sbr_req_o[s] && sbr_gnt_i[s];
      pop  = sbr_rvalid_i[s] && (fcnt_q[s] != CW'(0));
      if (push) begin
        fifo_d[s][fwptr_q[s]] = arb_win_s[s];
      end else begin
        fifo_d[s] = fifo_q[s];
      end
      fwptr_d[s] = !push ? fwptr_q[s] : (fwptr_q[s] == PW'(MaxTrans - 1)) ? PW'(0) : fwptr_q[s] + PW'(1);
      frptr_d[s] = !pop  ? frptr_q[s] : (frptr_q[s] == PW'(MaxTrans - 1)) ? PW'(0) : frptr_q[s] + PW'(1);
      case ({push, pop})
        2'b10:   fcnt_d[s] = fcnt_q[s] + CW'(1);
        2'b01:   fcnt_d[s] = fcnt_q[s] - CW'(1);
        default: fcnt_d[s] = fcnt_q[s];
      endcase
    end
    for (int m = 0; m < NumMgr; m++) begin
      case ({mgr_gnt_o[m], mgr_rvalid_o[m]})
        2'b10:   out_cnt_d[m] = out_cnt_q[m] + CW'(1);
        2'b01:   out_cnt_d[m] = out_cnt_q[m] - CW'(1);
        default: out_cnt_d[m] = out_cnt_q[m];
      endcase
      last_tgt_d[m] = mgr_gnt_o[m] ? tgt_s[m] : last_tgt_q[m];
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q  <= '0;
      last_tgt_q <= '0;
      rr_q       <= '0;
      fifo_q     <= '0;
      fwptr_q    <= '0;
      frptr_q    <= '0;
      fcnt_q     <= '0;
      err_vld_q  <= 1'b0;
      err_mgr_q  <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      last_tgt_q <= last_tgt_d;
      rr_q       <= rr_d;
      fifo_q     <= fifo_d;
      fwptr_q    <= fwptr_d;
      frptr_q    <= frptr_d;
      fcnt_q     <= fcnt_d;
      err_vld_q  <= err_vld_d;
      err_mgr_q  <= err_mgr_d;
    end
  end

`ifdef ZEROHETI_XBAR_STALL_CNT_EN
  logic [NumMgr-1:0][15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a manager requests without being granted.
  always_comb begin
    for (int m = 0; m < NumMgr; m++) begin
      if (clear_stall_i) begin
        stall_cnt_d[m] = 16'h0000;
      end else if (mgr_req_i[m] && !mgr_gnt_o[m] && (stall_cnt_q[m] != 16'hFFFF)) begin
        stall_cnt_d[m] = stall_cnt_q[m] + 16'h0001;
      end else begin
        stall_cnt_d[m] = stall_cnt_q[m];
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  zeroheti_obi_interconnect_chk #(.NumMgr(NumMgr), .CW(CW)) i_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mgr_rvalid_i (mgr_rvalid_o),
    .out_cnt_i    (out_cnt_q)
  );
endmodule

// Protocol checker: a response must never reach a manager with nothing outstanding.
module zeroheti_obi_interconnect_chk #(
  parameter int unsigned NumMgr = 3,
  parameter int unsigned CW     = 2
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  input logic [NumMgr-1:0]         mgr_rvalid_i,
  input logic [NumMgr-1:0][CW-1:0] out_cnt_i
);
  // Sample on each clock while out of reset.
  always @(posedge clk_i) begin
    for (int m = 0; m < NumMgr; m++) begin
      if (rst_ni && mgr_rvalid_i[m]) begin
        assert (out_cnt_i[m] != CW'(0)) else $error("rvalid to manager %0d with no outstanding transaction", m);
      end
    end
  end
endmodule

// File: tb/tb_zeroheti_obi_interconnect.sv
// Directed self-checking bench for zeroheti_obi_interconnect (3 managers, 6 subordinates, MaxTrans=2).
module tb_zeroheti_obi_interconnect;
  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [2:0]        mgr_req;
  logic [2:0][31:0]  mgr_addr;
  logic [2:0]        mgr_we;
  logic [2:0][3:0]   mgr_be;
  logic [2:0][31:0]  mgr_wdata;
  logic [2:0]        mgr_gnt;
  logic [2:0]        mgr_rvalid;
  logic [2:0][31:0]  mgr_rdata;
  logic [2:0]        mgr_err;
  logic [5:0]        sbr_req;
  logic [5:0][31:0]  sbr_addr;
  logic [5:0]        sbr_we;
  logic [5:0][3:0]   sbr_be;
  logic [5:0][31:0]  sbr_wdata;
  logic [5:0]        sbr_gnt;
  logic [5:0]        sbr_rvalid;
  logic [5:0][31:0]  sbr_rdata;
  logic [5:0]        sbr_err;
`ifdef ZEROHETI_XBAR_STALL_CNT_EN
  logic              clear_stall;
  logic [2:0][15:0]  stall_cnt;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  zeroheti_obi_interconnect #(
    .NumMgr      (3),
    .NumSbr      (6),
    .MaxTrans    (2),
    .AddrBase    ({32'h0000_5000, 32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .AddrLast    ({32'h0000_5FFF, 32'h0000_4FFF, 32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF}),
    .Connectivity(18'h3FEFF),
    .ErrRdata    (32'hBADCAB1E)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
`ifdef ZEROHETI_XBAR_STALL_CNT_EN
    .clear_stall_i(clear_stall),
    .stall_cnt_o  (stall_cnt),
`endif
    .mgr_req_i    (mgr_req),
    .mgr_addr_i   (mgr_addr),
    .mgr_we_i     (mgr_we),
    .mgr_be_i     (mgr_be),
    .mgr_wdata_i  (mgr_wdata),
    .mgr_gnt_o    (mgr_gnt),
    .mgr_rvalid_o (mgr_rvalid),
    .mgr_rdata_o  (mgr_rdata),
    .mgr_err_o    (mgr_err),
    .sbr_req_o    (sbr_req),
    .sbr_addr_o   (sbr_addr),
    .sbr_we_o     (sbr_we),
    .sbr_be_o     (sbr_be),
    .sbr_wdata_o  (sbr_wdata),
    .sbr_gnt_i    (sbr_gnt),
    .sbr_rvalid_i (sbr_rvalid),
    .sbr_rdata_i  (sbr_rdata),
    .sbr_err_i    (sbr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mgr_req = '0; mgr_addr = '0; mgr_we = '0; mgr_be = '0; mgr_wdata = '0;
    sbr_gnt = '0; sbr_rvalid = '0; sbr_rdata = '0; sbr_err = '0;
`ifdef ZEROHETI_XBAR_STALL_CNT_EN
    clear_stall = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    #3;
    chk("rst_sbr_req", 32'(sbr_req), 32'h0);
    chk("rst_gnt", 32'(mgr_gnt), 32'h0);
    chk("rst_rvalid", 32'(mgr_rvalid), 32'h0);
    chk("rst_err", 32'(mgr_err), 32'h0);
    chk("rst_rdata0", mgr_rdata[0], 32'h0);
    #10 rst_ni = 1'b1;
    tick();

    // Single read by mgr1 to imem.
    mgr_req[1] = 1'b1; mgr_addr[1] = 32'h0000_1000; mgr_be[1] = 4'hF; sbr_gnt[1] = 1'b1; #1;
    chk("t1_sbr_req", 32'(sbr_req), 32'h02);
    chk("t1_sbr_addr", sbr_addr[1], 32'h0000_1000);
    chk("t1_gnt", 32'(mgr_gnt), 32'h2);
    tick(); idle(); sbr_rvalid[1] = 1'b1; sbr_rdata[1] = 32'hDEADBEEF; #1;
    chk("t1_rvalid", 32'(mgr_rvalid), 32'h2);
    chk("t1_rdata", mgr_rdata[1], 32'hDEADBEEF);
    chk("t1_err", 32'(mgr_err), 32'h0);
    tick(); idle();

    // mgr0 and mgr2 contend for sbr2; sbr2 answers the cycle after each grant.
    mgr_req = 3'b101; mgr_addr[0] = 32'h0000_2000; mgr_addr[2] = 32'h0000_2004; sbr_gnt[2] = 1'b1; #1;
    chk("t2_c1_gnt", 32'(mgr_gnt), 32'h1);
    chk("t2_c1_addr", sbr_addr[2], 32'h0000_2000);
    tick(); sbr_rvalid[2] = 1'b1; sbr_rdata[2] = 32'hA000_0000; #1;
    chk("t2_c2_gnt", 32'(mgr_gnt), 32'h4);
    chk("t2_c2_addr", sbr_addr[2], 32'h0000_2004);
    chk("t2_c2_rvalid", 32'(mgr_rvalid), 32'h1);
    chk("t2_c2_rdata", mgr_rdata[0], 32'hA000_0000);
    tick(); sbr_rdata[2] = 32'hA000_0001; #1;
    chk("t2_c3_gnt", 32'(mgr_gnt), 32'h1);
    chk("t2_c3_rvalid", 32'(mgr_rvalid), 32'h4);
    chk("t2_c3_rdata", mgr_rdata[2], 32'hA000_0001);
    tick(); sbr_rdata[2] = 32'hA000_0002; #1;
    chk("t2_c4_gnt", 32'(mgr_gnt), 32'h4);
    chk("t2_c4_rvalid", 32'(mgr_rvalid), 32'h1);
    chk("t2_c4_rdata", mgr_rdata[0], 32'hA000_0002);
    tick(); mgr_req = '0; sbr_gnt = '0; sbr_rdata[2] = 32'hA000_0003; #1;
    chk("t2_c5_rvalid", 32'(mgr_rvalid), 32'h4);
    chk("t2_c5_rdata", mgr_rdata[2], 32'hA000_0003);
    tick(); idle();

    // Unmapped read by mgr2 hits the error responder.
    mgr_req[2] = 1'b1; mgr_addr[2] = 32'hFFFF_0000; #1;
    chk("t3_gnt", 32'(mgr_gnt), 32'h4);
    chk("t3_sbr_req", 32'(sbr_req), 32'h0);
    tick(); idle(); #1;
    chk("t3_rvalid", 32'(mgr_rvalid), 32'h4);
    chk("t3_err", 32'(mgr_err), 32'h4);
    chk("t3_rdata", mgr_rdata[2], 32'hBADCAB1E);
    tick(); idle();
    mgr_req[2] = 1'b1; mgr_addr[2] = 32'h0000_1000; sbr_gnt[1] = 1'b1; #1;
    chk("t3_cnt_zero_gnt", 32'(mgr_gnt), 32'h4);
    tick(); idle(); sbr_rvalid[1] = 1'b1; sbr_rdata[1] = 32'h1234_5678; #1;
    chk("t3_follow_rdata", mgr_rdata[2], 32'h1234_5678);
    tick(); idle();

    // MaxTrans limit: third back-to-back request stalls until the first response.
    mgr_req[1] = 1'b1; mgr_addr[1] = 32'h0000_1000; sbr_gnt[1] = 1'b1; #1;
    chk("t4_c1_gnt", 32'(mgr_gnt), 32'h2);
    tick(); #1;
    chk("t4_c2_gnt", 32'(mgr_gnt), 32'h2);
    tick(); #1;
    chk("t4_c3_gnt", 32'(mgr_gnt), 32'h0);
    tick(); tick(); tick(); sbr_rvalid[1] = 1'b1; sbr_rdata[1] = 32'hB000_0001; #1;
    chk("t4_c6_rvalid", 32'(mgr_rvalid), 32'h2);
    chk("t4_c6_rdata", mgr_rdata[1], 32'hB000_0001);
    tick(); sbr_rvalid = '0; #1;
    chk("t4_c7_gnt", 32'(mgr_gnt), 32'h2);
    tick(); idle(); sbr_rvalid[1] = 1'b1; sbr_rdata[1] = 32'hB000_0002; #1;
    chk("t4_c8_rdata", mgr_rdata[1], 32'hB000_0002);
    tick(); sbr_rdata[1] = 32'hB000_0003; #1;
    chk("t4_c9_rvalid", 32'(mgr_rvalid), 32'h2);
    chk("t4_c9_rdata", mgr_rdata[1], 32'hB000_0003);
    tick(); idle();

    // Target switch by mgr2 waits for its sbr2 response.
    mgr_req[2] = 1'b1; mgr_addr[2] = 32'h0000_2000; sbr_gnt[2] = 1'b1; #1;
    chk("t5_c1_gnt", 32'(mgr_gnt), 32'h4);
    tick(); mgr_addr[2] = 32'h0000_1000; sbr_gnt[1] = 1'b1; #1;
    chk("t5_c2_gnt", 32'(mgr_gnt), 32'h0);
    chk("t5_c2_sbr_req", 32'(sbr_req), 32'h0);
    tick(); #1;
    chk("t5_c3_gnt", 32'(mgr_gnt), 32'h0);
    tick(); sbr_rvalid[2] = 1'b1; sbr_rdata[2] = 32'hC000_0001; #1;
    chk("t5_c4_rvalid", 32'(mgr_rvalid), 32'h4);
    chk("t5_c4_rdata", mgr_rdata[2], 32'hC000_0001);
    tick(); sbr_rvalid = '0; #1;
    chk("t5_c5_gnt", 32'(mgr_gnt), 32'h4);
    chk("t5_c5_sbr_req", 32'(sbr_req), 32'h2);
    tick(); idle(); sbr_rvalid[1] = 1'b1; sbr_rdata[1] = 32'hC000_0002; #1;
    chk("t5_c6_rvalid", 32'(mgr_rvalid), 32'h4);
    chk("t5_c6_rdata", mgr_rdata[2], 32'hC000_0002);
    tick(); idle();

    // Connectivity hole: mgr1 to dmem is treated as unmapped.
    mgr_req[1] = 1'b1; mgr_addr[1] = 32'h0000_2000; sbr_gnt[2] = 1'b1; #1;
    chk("t6_gnt", 32'(mgr_gnt), 32'h2);
    chk("t6_sbr_req", 32'(sbr_req), 32'h0);
    tick(); idle(); #1;
    chk("t6_rvalid", 32'(mgr_rvalid), 32'h2);
    chk("t6_err", 32'(mgr_err), 32'h2);
    chk("t6_rdata", mgr_rdata[1], 32'hBADCAB1E);
    tick(); idle();

`ifdef ZEROHETI_XBAR_STALL_CNT_EN
    clear_stall = 1'b1;
    tick(); clear_stall = 1'b0; #1;
    chk("t7_cleared", 32'(stall_cnt[0]), 32'h0);
    mgr_req[0] = 1'b1; mgr_addr[0] = 32'h0000_1000;
    tick(); tick(); tick(); idle(); #1;
    chk("t7_stall_cnt", 32'(stall_cnt[0]), 32'h3);
    chk("t7_stall_other", 32'(stall_cnt[1]), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zeroheti_obi_interconnect.md
Name: zeroheti_obi_interconnect

Overview:
Parametrised OBI interconnect for zeroHETI cores, replacing the fixed 3x6 crossbar. It routes NumMgr manager ports (debug SBA, ibex instr, ibex data, optional extra masters) to NumSbr subordinate ports through a parameter address map, with round-robin arbitration per subordinate. It tracks outstanding transactions so responses return in order. Unmapped accesses are completed by an internal decode-error responder instead of hanging.

Parameters:
NumMgr, 3, number of manager (initiator) ports
NumSbr, 6, number of subordinate (target) ports
MaxTrans, 2, max outstanding transactions per manager and per subordinate (>=1)
AddrBase, all-zero, packed NumSbr x 32 region start addresses (inclusive)
AddrLast, all-zero, packed NumSbr x 32 region end addresses (inclusive)
Connectivity, all-ones, packed NumMgr x NumSbr; bit [m][s]=1 means manager m may reach subordinate s
ErrRdata, 32'hBADCAB1E, rdata returned on decode error

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mgr_req_i  in  NumMgr  OBI req per manager
mgr_addr_i  in  NumMgr x 32  address
mgr_we_i  in  NumMgr  write enable
mgr_be_i  in  NumMgr x 4  byte enables
mgr_wdata_i  in  NumMgr x 32  write data
mgr_gnt_o  out  NumMgr  grant
mgr_rvalid_o  out  NumMgr  response valid
mgr_rdata_o  out  NumMgr x 32  response data
mgr_err_o  out  NumMgr  response error
sbr_req_o  out  NumSbr  req per subordinate
sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o  out  per subordinate  forwarded request fields
sbr_gnt_i  in  NumSbr  grant
sbr_rvalid_i  in  NumSbr  response valid
sbr_rdata_i  in  NumSbr x 32  response data
sbr_err_i  in  NumSbr  response error

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous, active-low. Reset: all gnt/req/rvalid/err outputs 0, rdata 0, all FIFOs empty, RR pointers 0, counters 0.
- Decode: combinational. Lowest-index s with AddrBase[s]<=addr<=AddrLast[s] and Connectivity[m][s]=1 wins. No hit means target ERR.
- Per manager state: out_cnt (0..MaxTrans), last_tgt. Request is eligible iff out_cnt==0, or (out_cnt<MaxTrans and target==last_tgt). Otherwise gnt_o=0 (ordering stall).
- Per subordinate arbiter: round-robin among eligible requesting managers. Pointer advances to winner+1 (mod NumMgr) only on a completed handshake (sbr_req_o & sbr_gnt_i). A held losing request keeps its fields stable; the bus stays OBI-compliant.
- Forwarding is combinational: mgr_gnt_o[m] = sbr_gnt_i[s] for the chosen winner. Zero added request latency.
- Each subordinate has a FIFO of manager indices, depth MaxTrans, pushed on handshake. The subordinate's sbr_req_o is masked while its FIFO is full. sbr_rvalid_i pops the FIFO and routes rdata/err to the head manager in the same cycle (combinational response path).
- ERR responder: grants immediately (gnt=1 same cycle) when eligible, one at a time, round-robin across managers. Next cycle it asserts rvalid=1, err=1, rdata=ErrRdata to that manager.
- out_cnt: +1 on gnt, -1 on rvalid. Both in the same cycle means unchanged. An rvalid with out_cnt==0 is impossible by construction; it is flagged by assertion.
- A simultaneous response to the same manager from two sources cannot occur (single-target ordering rule).
- Reset mid-transaction drops all in-flight state. Subordinates are in the same reset domain.

Optional Feature:
Macro ZEROHETI_XBAR_STALL_CNT_EN. When defined, adds output stall_cnt_o (NumMgr x 16). Per manager it is a saturating count of cycles with req=1 and gnt=0 (arbitration, ordering or FIFO-full). It saturates at 16'hFFFF, resets to 0, and clears when the clear_stall_i input (1 bit, also added) is high. When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Mgr1 reads 0x1000 (imem, sbr1 gnt same cycle, rvalid+1, rdata 0xDEADBEEF) -> mgr1 gnt in cycle 0, rvalid/rdata 0xDEADBEEF in cycle 1, err=0.
- Mgr0 and mgr2 hold req to sbr2 for 4 cycles, sbr2 gnt always 1 -> grants alternate 0,2,0,2; each manager's 2 responses are routed correctly.
- Mgr2 read of unmapped 0xFFFF_0000 -> gnt same cycle, next cycle rvalid=1, err=1, rdata=0xBADCAB1E; out_cnt returns to 0.
- MaxTrans=2, sbr1 delays rvalid 5 cycles: mgr1 issues 3 back-to-back -> first 2 granted, third held until first rvalid, then granted.
- Mgr2 outstanding to sbr2, then requests sbr1 -> gnt=0 until sbr2 rvalid; granted in that cycle or later; responses arrive in order.
- Connectivity[1][2]=0, mgr1 reads dmem base -> error response as unmapped. With ZEROHETI_XBAR_STALL_CNT_EN, a 3-cycle stall yields stall_cnt_o[m]=3.
